// File: rtl/instr_receiver_pkg.sv
// Package shared by the instruction receiver slice.
// Holds the default instruction width and buffer depth, the FSM state
// encoding, and a helper that derives a buffer address width from a depth
// (minimum 1 bit, so that a single-entry buffer still has an address).
package instr_receiver_pkg;

  localparam int IWIDTH_DEF = 32;
  localparam int DEPTH_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RECV = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/instr_receiver_if.sv
// Bundles the transmitter handshake, the fetch-side read port and the status
// flags of instr_receiver.
//   slave  : the receiver (drives r_o_*; samples r_i_*)
//   master : the environment (transmitter + fetch + control)
// Signals:
//   r_i_start          load request pulse
//   r_o_syn            words wanted from the transmitter
//   r_i_instr/ack/last instruction word, its valid strobe, final-word marker
//   r_i_raddr/r_o_rdata fetch read address and registered read data
//   r_o_count          number of words stored
//   r_o_busy/done/err  state flags
interface instr_receiver_if
  import instr_receiver_pkg::*;
#(
  parameter int IWIDTH = IWIDTH_DEF,
  parameter int AWIDTH = addr_width(DEPTH_DEF)
);

  logic              r_i_start;
  logic              r_o_syn;
  logic [IWIDTH-1:0] r_i_instr;
  logic              r_i_ack;
  logic              r_i_last;
  logic [AWIDTH-1:0] r_i_raddr;
  logic [IWIDTH-1:0] r_o_rdata;
  logic [AWIDTH:0]   r_o_count;
  logic              r_o_busy;
  logic              r_o_done;
  logic              r_o_err;

  modport slave (
    input  r_i_start, r_i_instr, r_i_ack, r_i_last, r_i_raddr,
    output r_o_syn, r_o_rdata, r_o_count, r_o_busy, r_o_done, r_o_err
  );

  modport master (
    output r_i_start, r_i_instr, r_i_ack, r_i_last, r_i_raddr,
    input  r_o_syn, r_o_rdata, r_o_count, r_o_busy, r_o_done, r_o_err
  );

endinterface

// File: rtl/instr_buffer.sv
// Instruction storage: one synchronous write port and one registered read
// port. The array itself has no reset; the caller supplies rd_valid so that
// entries not written since the last load read back as zero.
// Ports:
//   t_clk, t_rst     clock, asynchronous active-low reset (read register only)
//   we/waddr/wdata   write port
//   raddr, rd_valid  read address and validity of that entry
//   rdata            registered read data (0 when the entry is not valid)
module instr_buffer #(
  parameter int IWIDTH = 32,
  parameter int DEPTH  = 8,
  parameter int AWIDTH = 3
) (
  input  logic              t_clk,
  input  logic              t_rst,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [IWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  input  logic              rd_valid,
  output logic [IWIDTH-1:0] rdata
);

  logic [IWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge t_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-blocking write above means a same-address read sees the old word.
  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) rdata <= '0;
    else        rdata <= rd_valid ? mem[raddr] : '0;
  end

endmodule

// File: rtl/instr_receiver.sv
// Instruction receiver: requests a program from a transmitter, stores the
// acked words into instr_buffer, and exposes them to a fetch-side read port.
// A load ends in DONE on a word flagged last, or in ERR on a first-ack
// timeout or on buffer overflow.
// Ports:
//   t_clk, t_rst  clock, asynchronous active-low reset
//   bus           instr_receiver_if slave modport (handshake, read, flags)
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | nothing loaded since reset; waiting for start
// REQ     | syn high, waiting for an ack; timeout down-counter running
// RECV    | previous cycle accepted a word; expecting the next ack
// DONE    | load finished on a last word; further acks ignored
// ERR     | timeout or overflow; further acks ignored until next start
module instr_receiver
  import instr_receiver_pkg::*;
#(
  parameter int IWIDTH  = IWIDTH_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int AWIDTH  = addr_width(DEPTH),
  parameter int TIMEOUT = 16
) (
  input  logic t_clk,
  input  logic t_rst,
  instr_receiver_if.slave bus
);

  localparam int TWIDTH = $clog2(TIMEOUT + 1);
  localparam logic [TWIDTH-1:0] TMR_LOAD = TWIDTH'(TIMEOUT);
  localparam logic [TWIDTH-1:0] TMR_TC   = TWIDTH'(1);
  localparam logic [AWIDTH:0]   CNT_LAST = (AWIDTH + 1)'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [AWIDTH:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [TWIDTH-1:0] tmr_q, tmr_d;
  logic              syn_q, busy_q, done_q, err_q;
  logic              we;
  logic              accept;
  logic              rd_valid;

  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      tmr_q   <= '0;
      syn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      tmr_q   <= tmr_d;
      // Flags are registered from the next state so they line up with it.
      syn_q   <= (state_d == ST_REQ) || (state_d == ST_RECV);
      busy_q  <= (state_d == ST_REQ) || (state_d == ST_RECV);
      done_q  <= (state_d == ST_DONE);
      err_q   <= (state_d == ST_ERR);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    tmr_d   = tmr_q;
    we      = 1'b0;
    accept  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (bus.r_i_start) begin
          state_d = ST_REQ;
          cnt_d   = '0;
          valid_d = '0;
          tmr_d   = TMR_LOAD;
        end
      end
      ST_REQ: begin
        if (bus.r_i_ack) begin
          accept = 1'b1;
        end else if (tmr_q == TMR_TC) begin
          state_d = ST_ERR;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q - TMR_TC;
        end
      end
      ST_RECV: begin
        if (bus.r_i_ack) begin
          accept = 1'b1;
        end else begin
          state_d = ST_REQ;
          tmr_d   = TMR_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      we = 1'b1;
      valid_d[cnt_q[AWIDTH-1:0]] = 1'b1;
      cnt_d = cnt_q + 1'b1;
      tmr_d = '0;
      if (bus.r_i_last)           state_d = ST_DONE;
      else if (cnt_q == CNT_LAST) state_d = ST_ERR;
      else                        state_d = ST_RECV;
    end
  end

  // Addresses beyond DEPTH exist only when DEPTH is not a power of two.
  if (DEPTH == (1 << AWIDTH)) begin : g_rd_full
    assign rd_valid = valid_q[bus.r_i_raddr];
  end else begin : g_rd_part
    assign rd_valid = ({1'b0, bus.r_i_raddr} < (AWIDTH + 1)'(DEPTH)) ?
                      valid_q[bus.r_i_raddr] : 1'b0;
  end

  instr_buffer #(
    .IWIDTH (IWIDTH),
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) u_buf (
    .t_clk    (t_clk),
    .t_rst    (t_rst),
    .we       (we),
    .waddr    (cnt_q[AWIDTH-1:0]),
    .wdata    (bus.r_i_instr),
    .raddr    (bus.r_i_raddr),
    .rd_valid (rd_valid),
    .rdata    (bus.r_o_rdata)
  );

  assign bus.r_o_syn   = syn_q;
  assign bus.r_o_count = cnt_q;
  assign bus.r_o_busy  = busy_q;
  assign bus.r_o_done  = done_q;
  assign bus.r_o_err   = err_q;

endmodule

// File: tb/tb_instr_receiver.sv
module tb_instr_receiver;

  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int TO    = 16;

  logic t_clk = 1'b0;
  logic t_rst = 1'b0;
  always #5 t_clk = ~t_clk;

  instr_receiver_if #(.IWIDTH(IW), .AWIDTH(AW)) bus ();

  instr_receiver #(
    .IWIDTH (IW),
    .DEPTH  (DEPTH),
    .AWIDTH (AW),
    .TIMEOUT(TO)
  ) dut (
    .t_clk (t_clk),
    .t_rst (t_rst),
    .bus   (bus)
  );

  typedef struct {
    int          nw;
    bit          last_on_final;
    bit          toggle;
    bit          start_mid;
    logic [31:0] base;
    logic        exp_done;
    logic        exp_err;
    int          exp_cnt;
  } scen_t;

  scen_t       scen [5];
  logic [31:0] rdq [$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic tick();
    @(posedge t_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word i of a stream with base b is b*(i+1): base 0x11 gives 0x11..0x44.
  function automatic logic [31:0] word(input logic [31:0] b, input int i);
    return b * (i + 1);
  endfunction

  task automatic read_all(input int nw, input logic [31:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      bus.r_i_raddr = AW'(i);
      rdq.push_back((i < nw) ? word(base, i) : 32'h0);
      tick();
      check($sformatf("rdata[%0d]", i), bus.r_o_rdata, rdq.pop_front());
    end
  endtask

  task automatic run_scen(input scen_t s);
    bus.r_i_start = 1'b1;
    tick();
    bus.r_i_start = 1'b0;
    check("syn_after_start", {31'b0, bus.r_o_syn}, 32'd1);
    check("busy_after_start", {31'b0, bus.r_o_busy}, 32'd1);
    for (int i = 0; i < s.nw; i++) begin
      bus.r_i_ack   = 1'b1;
      bus.r_i_instr = word(s.base, i);
      bus.r_i_last  = s.last_on_final && (i == s.nw - 1);
      bus.r_i_start = s.start_mid && (i == 2);
      tick();
      bus.r_i_ack   = 1'b0;
      bus.r_i_last  = 1'b0;
      bus.r_i_start = 1'b0;
      if (s.toggle && i != s.nw - 1) tick();
    end
    check("syn_after_last", {31'b0, bus.r_o_syn}, 32'd0);
    check("done", {31'b0, bus.r_o_done}, {31'b0, s.exp_done});
    check("err", {31'b0, bus.r_o_err}, {31'b0, s.exp_err});
    check("count", {29'b0, bus.r_o_count}, s.exp_cnt);
    // Trailing word one cycle after last must be dropped.
    bus.r_i_ack   = 1'b1;
    bus.r_i_instr = 32'hDEAD_BEEF;
    tick();
    bus.r_i_ack   = 1'b0;
    check("count_after_trailing", {29'b0, bus.r_o_count}, s.exp_cnt);
    read_all(s.exp_cnt, s.base);
  endtask

  initial begin
    int n;
    bus.r_i_start = 1'b0;
    bus.r_i_instr = '0;
    bus.r_i_ack   = 1'b0;
    bus.r_i_last  = 1'b0;
    bus.r_i_raddr = '0;

    //             nw last tog mid  base          done  err   cnt
    scen[0] = '{4, 1'b1, 1'b0, 1'b0, 32'h11,       1'b1, 1'b0, 4};
    scen[1] = '{4, 1'b1, 1'b1, 1'b0, 32'h0101_0101, 1'b1, 1'b0, 4};
    scen[2] = '{4, 1'b0, 1'b0, 1'b0, 32'h5,        1'b0, 1'b1, 4};
    scen[3] = '{2, 1'b1, 1'b0, 1'b0, 32'h7,        1'b1, 1'b0, 2};
    scen[4] = '{4, 1'b1, 1'b0, 1'b1, 32'h21,       1'b1, 1'b0, 4};

    repeat (3) tick();
    check("rst_syn", {31'b0, bus.r_o_syn}, 32'd0);
    check("rst_count", {29'b0, bus.r_o_count}, 32'd0);
    check("rst_busy", {31'b0, bus.r_o_busy}, 32'd0);
    check("rst_done", {31'b0, bus.r_o_done}, 32'd0);
    check("rst_err", {31'b0, bus.r_o_err}, 32'd0);
    check("rst_rdata", bus.r_o_rdata, 32'd0);
    t_rst = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) run_scen(scen[k]);

    // Timeout: no acks at all.
    bus.r_i_start = 1'b1;
    tick();
    bus.r_i_start = 1'b0;
    n = 0;
    while (bus.r_o_err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, TO);
    check("timeout_syn", {31'b0, bus.r_o_syn}, 32'd0);
    check("timeout_count", {29'b0, bus.r_o_count}, 32'd0);

    // Reset in the middle of a load.
    bus.r_i_start = 1'b1;
    tick();
    bus.r_i_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.r_i_ack   = 1'b1;
      bus.r_i_instr = word(32'h13, i);
      tick();
    end
    bus.r_i_ack = 1'b0;
    check("pre_rst_count", {29'b0, bus.r_o_count}, 32'd2);
    t_rst = 1'b0;
    #1;
    check("midrst_syn", {31'b0, bus.r_o_syn}, 32'd0);
    check("midrst_count", {29'b0, bus.r_o_count}, 32'd0);
    check("midrst_busy", {31'b0, bus.r_o_busy}, 32'd0);
    t_rst = 1'b1;
    tick();
    read_all(0, 32'h0);
    run_scen(scen[0]);

    // Ack injected while DONE.
    bus.r_i_ack   = 1'b1;
    bus.r_i_instr = 32'hBAD0_BAD0;
    bus.r_i_last  = 1'b1;
    tick();
    bus.r_i_ack   = 1'b0;
    bus.r_i_last  = 1'b0;
    check("done_ack_count", {29'b0, bus.r_o_count}, 32'd4);
    check("done_ack_done", {31'b0, bus.r_o_done}, 32'd1);
    read_all(4, 32'h11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
